// File: rtl/dmem_responder.sv
// Single-port data memory that answers one load/store request at a time after a
// fixed, parameterised latency, with alignment, range and opcode checking.
module dmem_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          AW      = 10,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [31:0] MEM_BYTES = 32'd4 << AW;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        do_access;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wen_q;
  logic [2:0]  op_q;

  logic [31:0] mem [2**AW];

  // ---------------------------------------------------------------------------
  // Access operands: taken straight from the request port when the access
  // happens on the accepting edge (LATENCY==1), otherwise from the latched copy.
  // ---------------------------------------------------------------------------
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_wen;
  logic [2:0]  a_op;

  assign a_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign a_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign a_wen   = (state == IDLE) ? req_wen   : wen_q;
  assign a_op    = (state == IDLE) ? req_op    : op_q;

  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          out_of_range;
  logic          op_legal;
  logic          misaligned;
  logic          acc_err;

  assign offset       = a_addr - BASE;
  assign word_idx     = offset[AW+1:2];
  assign out_of_range = (offset >= MEM_BYTES);
  assign op_legal     = (a_op == OP_B) || (a_op == OP_H) || (a_op == OP_W) ||
                        (a_op == OP_BU) || (a_op == OP_HU);
  assign misaligned   = ((a_op[1:0] == 2'b01) && a_addr[0]) ||
                        ((a_op[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
  assign acc_err      = out_of_range || !op_legal || (a_wen && a_op[2]) || misaligned;

  // ---------------------------------------------------------------------------
  // Load path: shift the addressed lane down to bit 0, then extend.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [31:0] rd_lane;
  logic [31:0] load_data;

  assign rd_word = mem[word_idx];
  assign rd_lane = rd_word >> {a_addr[1:0], 3'b000};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a value held (latch).
    load_data = '0;
    case (a_op)
      OP_B:    load_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
      OP_H:    load_data = {{16{rd_lane[15]}}, rd_lane[15:0]};
      OP_W:    load_data = rd_word;
      OP_BU:   load_data = {24'd0, rd_lane[7:0]};
      OP_HU:   load_data = {16'd0, rd_lane[15:0]};
      default: load_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store path: replicate the right-aligned data across lanes and enable only
  // the addressed bytes.
  // ---------------------------------------------------------------------------
  logic [3:0]  wr_be;
  logic [31:0] wr_word;

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = a_wdata;
    case (a_op[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << a_addr[1:0];
        wr_word = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = a_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{a_wdata[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_word = a_wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_word = a_wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            do_access = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = 4'(LATENCY - 1);
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // The access fires on the edge where the counter reaches zero.
        if (cnt <= 4'd1) begin
          do_access = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      op_q       <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wen_q   <= req_wen;
        op_q    <= req_op;
      end
      if (do_access) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || a_wen) ? 32'd0 : load_data;
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive rst, and only the
  // write enable is gated so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!rst && do_access && a_wen && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder, checked against a byte-level
// memory model; a second instance exercises the single-cycle latency case.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          REGION = 64;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_op;

  // LATENCY=1 instance
  logic        req_valid1, req_ready1, req_wen1, resp_valid1, resp_ready1, resp_err1;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1;
  logic [2:0]  req_op1;

  dmem_responder #(.BASE(BASE), .AW(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_op(req_op), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.BASE(BASE), .AW(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .req_wen(req_wen1), .req_op(req_op1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  int checks = 0;
  int errors = 0;

  // Byte-level reference model of the first REGION bytes above BASE.
  logic [7:0] mb [REGION];

  function automatic int op_bytes(input logic [2:0] o);
    return (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic w, input logic [2:0] o);
    logic [31:0] off;
    logic        legal, mis;
    off   = a - BASE;
    legal = (o == 3'd0) || (o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd5);
    mis   = ((o[1:0] == 2'b01) && (a % 2 != 0)) || ((o[1:0] == 2'b10) && (a % 4 != 0));
    return (off >= 32'd4096) || !legal || (w && o[2]) || mis;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] o);
    longint val;
    int     n, off;
    n   = op_bytes(o);
    off = int'(a - BASE);
    val = 0;
    for (int i = 0; i < n; i++) val += longint'(mb[off+i]) << (8*i);
    if (!o[2] && n < 4 && val >= (longint'(1) << (8*n-1)))
      val += (longint'(1) << 32) - (longint'(1) << (8*n));
    return 32'(val);
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] o, input logic [31:0] d);
    int n, off;
    n   = op_bytes(o);
    off = int'(a - BASE);
    for (int i = 0; i < n; i++) mb[off+i] = 8'(d >> (8*i));
  endtask

  // Expected response for one access; updates the model for successful stores.
  task automatic model_access(input logic [31:0] a, input logic w, input logic [2:0] o,
                              input logic [31:0] d, output logic [31:0] erd, output logic eer);
    eer = exp_err(a, w, o);
    erd = 32'd0;
    if (!eer && w) model_store(a, o, d);
    if (!eer && !w) erd = model_load(a, o);
  endtask

  // One transaction on the LATENCY=2 instance. lat counts cycles from the
  // accepting cycle (0) to the first cycle with resp_valid; 99 means timeout.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [2:0] o,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output bit stable, output bit ready_after);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_wen = w; req_op = o; req_wdata = d;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wen = 1'($urandom); req_op = 3'($urandom); req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    stable = 1'b1;
    if (!resp_valid) begin
      lat = 99;
      stable = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0) stable = 1'b0;
      req_valid = 1'($urandom);
      req_addr  = $urandom;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready  = 1'b0;
    ready_after = req_ready && !resp_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_op = '0; req_wdata = '0; resp_ready = 1'b0;
    req_valid1 = 1'b0; req_addr1 = '0; req_wen1 = 1'b0; req_op1 = '0; req_wdata1 = '0; resp_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b err=%b rdata=%h required 0/0/0", resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (resp_valid1 !== 1'b0 || resp_err1 !== 1'b0 || resp_rdata1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs_l1: valid=%b err=%b rdata=%h required 0/0/0", resp_valid1, resp_err1, resp_rdata1);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || req_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b req_ready1=%b required 1/1", req_ready, req_ready1);
    end
  endtask

  // Fills the model region with random words so every later load is defined.
  task automatic test_preload;
    logic [31:0] rd, erd, d;
    logic er, eer;
    int lat;
    bit st, ra;
    for (int i = 0; i < REGION / 4; i++) begin
      d = $urandom;
      model_access(BASE + 32'(4*i), 1'b1, 3'b010, d, erd, eer);
      do_req(BASE + 32'(4*i), 1'b1, 3'b010, d, 0, rd, er, lat, st, ra);
      checks++;
      if (rd !== erd || er !== eer || lat != 2) begin
        errors++;
        $display("FAIL preload_sw[%0d]: rdata=%h err=%b lat=%0d required %h/%b/2", i, rd, er, lat, erd, eer);
      end
    end
  endtask

  task automatic test_word;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    bit st, ra;
    model_access(32'h8000_0010, 1'b1, 3'b010, 32'h1234_5678, erd, eer);
    do_req(32'h8000_0010, 1'b1, 3'b010, 32'h1234_5678, 0, rd, er, lat, st, ra);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL sw_word: rdata=%h err=%b lat=%0d required 0/0/2", rd, er, lat);
    end
    model_access(32'h8000_0010, 1'b0, 3'b010, 32'd0, erd, eer);
    do_req(32'h8000_0010, 1'b0, 3'b010, 32'd0, 0, rd, er, lat, st, ra);
    checks++;
    if (rd !== 32'h1234_5678 || er !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL lw_word: rdata=%h err=%b lat=%0d required 12345678/0/2", rd, er, lat);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    bit st, ra;
    logic [31:0] req_a [4];
    logic [2:0]  req_o [4];
    logic        req_w [4];
    logic [31:0] want  [4];
    req_a = '{32'h8000_0013, 32'h8000_0013, 32'h8000_0013, 32'h8000_0010};
    req_o = '{3'b000, 3'b000, 3'b100, 3'b010};
    req_w = '{1'b1, 1'b0, 1'b0, 1'b0};
    want  = '{32'h0000_0000, 32'hFFFF_FFA5, 32'h0000_00A5, 32'hA534_5678};
    for (int i = 0; i < 4; i++) begin
      model_access(req_a[i], req_w[i], req_o[i], 32'hFFFF_FFA5, erd, eer);
      do_req(req_a[i], req_w[i], req_o[i], 32'hFFFF_FFA5, 0, rd, er, lat, st, ra);
      checks++;
      if (rd !== want[i] || er !== 1'b0 || rd !== erd) begin
        errors++;
        $display("FAIL byte_seq[%0d]: rdata=%h err=%b required %h/0", i, rd, er, want[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    bit st, ra;
    logic [31:0] req_a [4];
    logic [2:0]  req_o [4];
    logic        req_w [4];
    req_a = '{32'h8000_0002, 32'h8000_0001, 32'h8000_1000, 32'h8000_0000};
    req_o = '{3'b010, 3'b001, 3'b010, 3'b011};
    req_w = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_req(req_a[i], req_w[i], req_o[i], 32'hCAFE_F00D, 0, rd, er, lat, st, ra);
      checks++;
      if (rd !== 32'd0 || er !== 1'b1 || lat != 2) begin
        errors++;
        $display("FAIL error_case[%0d]: rdata=%h err=%b lat=%0d required 0/1/2", i, rd, er, lat);
      end
    end
    model_access(32'h8000_0000, 1'b0, 3'b010, 32'd0, erd, eer);
    do_req(32'h8000_0000, 1'b0, 3'b010, 32'd0, 0, rd, er, lat, st, ra);
    checks++;
    if (rd !== erd || er !== 1'b0) begin
      errors++;
      $display("FAIL error_no_write: rdata=%h err=%b required %h/0", rd, er, erd);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    bit st, ra;
    model_access(32'h8000_0014, 1'b0, 3'b010, 32'd0, erd, eer);
    do_req(32'h8000_0014, 1'b0, 3'b010, 32'd0, 5, rd, er, lat, st, ra);
    checks++;
    if (rd !== erd || er !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL backpressure_data: rdata=%h err=%b lat=%0d required %h/0/2", rd, er, lat, erd);
    end
    checks++;
    if (st !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_stable: stable=%b required 1", st);
    end
    checks++;
    if (ra !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: ready_after=%b required 1", ra);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, seen;
    bit st, ra;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0020; req_wen = 1'b1; req_op = 3'b010; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_resp: resp cycles=%0d req_ready=%b required 0/1", seen, req_ready);
    end
    model_access(32'h8000_0020, 1'b0, 3'b010, 32'd0, erd, eer);
    do_req(32'h8000_0020, 1'b0, 3'b010, 32'd0, 0, rd, er, lat, st, ra);
    checks++;
    if (rd !== erd || er !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL abort_no_write: rdata=%h err=%b lat=%0d required %h/0/2", rd, er, lat, erd);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, d, rd, erd;
    logic [2:0]  o;
    logic        w, er, eer;
    int lat, sel;
    bit st, ra;
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = BASE + 32'($urandom_range(0, REGION - 1));
      else if (sel == 8) a = BASE + 32'd4096 + 32'($urandom_range(0, 1000));
      else               a = BASE - 32'd1 - 32'($urandom_range(0, 1000));
      o = 3'($urandom);
      w = 1'($urandom);
      d = $urandom;
      model_access(a, w, o, d, erd, eer);
      do_req(a, w, o, d, int'($urandom_range(0, 2)), rd, er, lat, st, ra);
      checks++;
      if (rd !== erd || er !== eer || lat != 2 || !st || !ra) begin
        errors++;
        $display("FAIL random[%0d] a=%h w=%b op=%b: rdata=%h err=%b lat=%0d st=%b ra=%b required %h/%b/2/1/1",
                 i, a, w, o, rd, er, lat, st, ra, erd, eer);
      end
    end
  endtask

  // Back-to-back traffic on the LATENCY=1 instance with resp_ready tied high.
  task automatic run_l1(input logic w, input logic [31:0] words [4]);
    int acc [4];
    int rsp [4];
    logic [31:0] rdat [4];
    logic        rerr [4];
    int k, r;
    for (int i = 0; i < 4; i++) begin acc[i] = -100; rsp[i] = -1; rdat[i] = 'x; rerr[i] = 'x; end
    k = 0;
    r = 0;
    resp_ready1 = 1'b1;
    for (int c = 0; c < 30 && r < 4; c++) begin
      @(negedge clk);
      if (resp_valid1) begin
        rsp[r] = c; rdat[r] = resp_rdata1; rerr[r] = resp_err1; r++;
      end
      if (req_ready1 && k < 4) begin
        req_valid1 = 1'b1; req_addr1 = BASE + 32'h100 + 32'(4*k);
        req_wen1 = w; req_op1 = 3'b010; req_wdata1 = words[k];
        acc[k] = c; k++;
      end else if (req_ready1) begin
        req_valid1 = 1'b0;
      end
    end
    @(negedge clk);
    req_valid1  = 1'b0;
    resp_ready1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp[i] - acc[i] != 1 || rdat[i] !== (w ? 32'd0 : words[i]) || rerr[i] !== 1'b0) begin
        errors++;
        $display("FAIL l1_resp[%0d] w=%b: lat=%0d rdata=%h err=%b required 1/%h/0",
                 i, w, rsp[i] - acc[i], rdat[i], rerr[i], w ? 32'd0 : words[i]);
      end
      if (i > 0) begin
        checks++;
        if (acc[i] - acc[i-1] != 2) begin
          errors++;
          $display("FAIL l1_spacing[%0d] w=%b: gap=%0d required 2", i, w, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_latency1;
    logic [31:0] words [4];
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    run_l1(1'b1, words);
    run_l1(1'b0, words);
  endtask

  initial begin
    test_reset;
    test_preload;
    test_word;
    test_byte;
    test_errors;
    test_backpressure;
    test_reset_abort;
    test_random;
    test_latency1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
